// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit (FSM state codes, access sizes, base byte-enable masks)
package lsu_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
endpackage

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: req/gnt/rvalid data bus between the LSU (master) and memory (slave)
//   req/we/addr/wdata/be  master -> slave request channel
//   gnt                   slave accepts the request this cycle
//   rvalid/rdata/err      slave response (reads and writes)
interface lsu_bus_if;
  logic req, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  modport master(output req, we, addr, wdata, be, input gnt, rvalid, rdata, err);
  modport slave(input req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane logic for one access
//   size/off      access size and effective byte offset within the word
//   unsgn         zero-extend loads instead of sign-extending
//   wd -> be/wdata   store byte enables and lane-replicated data
//   rd -> rdata      load lane extraction and extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsgn,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  assign sh    = rd >> {off, 3'b000};
  assign be    = size == SZ_B ? BE_B << off : size == SZ_H ? BE_H << {off[1], 1'b0} : BE_W;
  assign wdata = size == SZ_B ? {4{wd[7:0]}} : size == SZ_H ? {2{wd[15:0]}} : wd;
  assign rdata = size == SZ_B ? {{24{~unsgn & sh[7]}}, sh[7:0]} :
                 size == SZ_H ? {{16{~unsgn & sh[15]}}, sh[15:0]} : rd;
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit bridging the core memory port to a req/gnt/rvalid bus, stalling the core per access
//   clk, reset (async, active-low)
//   MemRead/MemWrite/Funct3/Mem_WrAddr/Mem_WrData  core access request
//   ReadData/Stall/Fault                           core response; ReadData and Fault valid in DONE
//   bus                                            lsu_bus_if master
//   LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault without touching the bus;
//   otherwise the offending low address bits are forced to zero.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  lsu_bus_if.master   bus
);
  localparam int CW = $clog2(BUS_TIMEOUT);
  logic [1:0] state, size_q, off_q, eff_off;
  logic [CW-1:0] cnt;
  logic unsgn_q, access, illegal, timeout;
  logic [3:0] st_be, unused_ld_be;
  logic [31:0] st_wdata, ld_rdata, unused_st_rdata, unused_ld_wdata;
  assign access  = MemRead | MemWrite;
  assign timeout = cnt == CW'(BUS_TIMEOUT - 1);
`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (Funct3[1:0] == SZ_H & Mem_WrAddr[0]) | (Funct3[1:0] == SZ_W & |Mem_WrAddr[1:0]);
  assign illegal  = (MemRead & MemWrite) | (Funct3[1:0] == 2'b11) | misalign;
`else
  assign illegal  = (MemRead & MemWrite) | (Funct3[1:0] == 2'b11);
`endif
  // Offset bits below the access size are dropped so a misaligned access lands on its aligned lanes
  assign eff_off = Funct3[1:0] == SZ_B ? Mem_WrAddr[1:0] : Funct3[1:0] == SZ_H ? {Mem_WrAddr[1], 1'b0} : 2'b00;
  // Gated by reset so every core-facing output is low while reset is held
  assign Stall   = reset & (state == ST_IDLE ? access : state != ST_DONE);
  assign bus.req = state == ST_REQ;
  lsu_lane_align u_st (
    .size(Funct3[1:0]), .unsgn(1'b0), .off(eff_off), .wd(Mem_WrData), .rd(32'h0),
    .be(st_be), .wdata(st_wdata), .rdata(unused_st_rdata)
  );
  lsu_lane_align u_ld (
    .size(size_q), .unsgn(unsgn_q), .off(off_q), .wd(32'h0), .rd(bus.rdata),
    .be(unused_ld_be), .wdata(unused_ld_wdata), .rdata(ld_rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      bus.be    <= '0;
      ReadData  <= '0;
      Fault     <= 1'b0;
      size_q    <= '0;
      unsgn_q   <= 1'b0;
      off_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (access) begin
          if (illegal) begin
            state    <= ST_DONE;
            Fault    <= 1'b1;
            ReadData <= '0;
          end else begin
            state     <= ST_REQ;
            cnt       <= '0;
            bus.we    <= MemWrite;
            bus.addr  <= {Mem_WrAddr[31:2], 2'b00};
            bus.wdata <= st_wdata;
            bus.be    <= st_be;
            size_q    <= Funct3[1:0];
            unsgn_q   <= Funct3[2];
            off_q     <= eff_off;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            state    <= ST_DONE;
            Fault    <= 1'b1;
            ReadData <= '0;
          end else if (bus.gnt) state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.rvalid) begin
            state    <= ST_DONE;
            Fault    <= bus.err;
            ReadData <= bus.we ? '0 : ld_rdata;
          end else if (timeout) begin
            state    <= ST_DONE;
            Fault    <= 1'b1;
            ReadData <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          Fault    <= 1'b0;
          ReadData <= '0;
        end
      endcase
    end
  end
endmodule
